// File: rtl/entrada_operandos_pkg.sv
// entrada_operandos_pkg: shared phase encodings and default debounce length
package entrada_operandos_pkg;

    localparam logic [1:0] ESPERA_A    = 2'b00;
    localparam logic [1:0] ESPERA_B    = 2'b01;
    localparam logic [1:0] RESULTADO   = 2'b10;
    localparam logic [1:0] FASE_ILEGAL = 2'b11;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/entrada_operandos_filtro_botao.sv
// filtro_botao: 2-FF synchroniser, debounce and rising-edge pulse for one raw button
module filtro_botao #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

    logic [1:0]    sync;
    logic          deb;
    logic          deb_q;
    logic [CW-1:0] cnt;

    // Level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync  <= '0;
            deb   <= 1'b0;
            deb_q <= 1'b0;
            cnt   <= '0;
        end else begin
            sync  <= {sync[0], raw};
            deb_q <= deb;
            if (sync[1] == deb)
                cnt <= '0;
            else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                deb <= ~deb;
                cnt <= '0;
            end else
                cnt <= cnt + CW'(1);
        end
    end

    assign pulse = deb & ~deb_q;

endmodule

// File: rtl/entrada_operandos.sv
// entrada_operandos: captures operand A then B from shared switches on ENTER presses
module entrada_operandos
    import entrada_operandos_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic       btn_enter,
    input  logic       btn_clear,
    output logic [3:0] op_a,
    output logic [3:0] op_b,
    output logic       valid,
    output logic [1:0] fase
);

    logic [3:0] sw_m;
    logic [3:0] sw_s;
    logic       enter_pulse;
    logic       clear_pulse;

    filtro_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_enter),
        .pulse (enter_pulse)
    );

    filtro_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_clear),
        .pulse (clear_pulse)
    );

    // Switch synchroniser plus operand FSM; clear (or an illegal phase) always wins over enter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_m  <= '0;
            sw_s  <= '0;
            op_a  <= '0;
            op_b  <= '0;
            valid <= 1'b0;
            fase  <= ESPERA_A;
        end else begin
            sw_m <= sw;
            sw_s <= sw_m;
            if (clear_pulse || fase == FASE_ILEGAL) begin
                op_a  <= '0;
                op_b  <= '0;
                valid <= 1'b0;
                fase  <= ESPERA_A;
            end else if (enter_pulse) begin
                case (fase)
                    ESPERA_A: begin
                        op_a <= sw_s;
                        fase <= ESPERA_B;
                    end
                    ESPERA_B: begin
                        op_b  <= sw_s;
                        valid <= 1'b1;
                        fase  <= RESULTADO;
                    end
                    default: begin
                        op_a  <= sw_s;
                        op_b  <= '0;
                        valid <= 1'b0;
                        fase  <= ESPERA_B;
                    end
                endcase
            end
        end
    end

endmodule
